// File: rtl/sevenseg_pkg.sv
// ============================================================================
// sevenseg_pkg: shared scan-controller state encoding and segment constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sevenseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_invalid(input logic [3:0] bcd);
    return (bcd > BCD_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_sevenseg.sv
// ============================================================================
// Sevenseg: BCD to active-high segment decoder, output order {g,f,e,d,c,b,a}.
// Revision: 1.0
// ============================================================================
`default_nettype none

module Sevenseg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
// ============================================================================
// sevenseg_scan_ctrl: double-buffered, guard-blanked multiplexed display scan.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_in_i,
  input  logic                    lz_en_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_n_o,
  output logic                    upd_o,
  output logic                    frame_done_o
);

  localparam int c_CNT_W = $clog2(REFRESH_DIV);
  localparam int c_IDX_W = $clog2(NUM_DIGITS);
  localparam int c_DAT_W = 4 * NUM_DIGITS;

  localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]    c_BLANK_END = c_CNT_W'(BLANK_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]    c_SLOT_END  = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0]    c_IDX_ONE   = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE    = NUM_DIGITS'(1);

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [c_DAT_W-1:0]   pbuf_q, pbuf_d;
  logic [c_DAT_W-1:0]   act_q, act_d;
  logic [6:0]           seg_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                 upd_q;
  logic                 frame_done_q;

  logic                 w_boundary;
  logic                 w_frame_end;
  logic                 w_xfer;
  logic [3:0]           w_bcd;
  logic [6:0]           w_dec_seg;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                 w_show;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pbuf_d      = pbuf_q;
    act_d       = act_q;
    w_boundary  = 1'b0;
    w_frame_end = 1'b0;
    w_xfer      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_BLANK;
          cnt_d      = '0;
          idx_d      = '0;
          w_boundary = 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt_q == c_BLANK_END) begin
          state_d = S_SHOW;
        end
        cnt_d = cnt_q + c_CNT_ONE;
      end
      S_SHOW: begin
        if (cnt_q == c_SLOT_END) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == c_IDX_LAST) begin
            idx_d       = '0;
            w_boundary  = 1'b1;
            w_frame_end = 1'b1;
          end else begin
            idx_d = idx_q + c_IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Transfer uses the old pending word, so a coincident load stays pending.
    w_xfer = w_boundary && pend_q;
    if (w_xfer) begin
      act_d  = pbuf_q;
      pend_d = 1'b0;
    end
    if (load_i) begin
      pbuf_d = digits_in_i;
      pend_d = 1'b1;
    end
  end

  assign w_bcd = act_d[{idx_d, 2'b00} +: 4];

  Sevenseg u_dec (
    .bcd_i (w_bcd),
    .seg_o (w_dec_seg)
  );

  // w_lz[i]: digit i and everything above it are zero; digit 0 never qualifies.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = (act_d[c_DAT_W-1:4*gi] == '0);
      end
    end
  endgenerate

  assign w_show = (state_d == S_SHOW) && !bcd_invalid(w_bcd)
                  && !(lz_en_i && w_lz[idx_d]);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pbuf_q       <= '0;
      act_q        <= '0;
      seg_q        <= SEG_OFF;
      an_n_q       <= '1;
      upd_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pbuf_q       <= pbuf_d;
      act_q        <= act_d;
      seg_q        <= w_show ? w_dec_seg : SEG_OFF;
      an_n_q       <= w_show ? ~(c_AN_ONE << idx_d) : '1;
      upd_q        <= w_xfer;
      frame_done_q <= w_frame_end;
    end
  end

  assign seg_o        = seg_q;
  assign an_n_o       = an_n_q;
  assign upd_o        = upd_q;
  assign frame_done_o = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
// ============================================================================
// tb_sevenseg_scan_ctrl: directed scenarios for the 4-digit scan controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sevenseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic [3:0]  an_n;
  logic        upd;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .load_i       (load),
    .digits_in_i  (digits_in),
    .lz_en_i      (lz_en),
    .seg_o        (seg),
    .an_n_o       (an_n),
    .upd_o        (upd),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an_n, seg} k cycles after the first BLANK; segs = {d3,d2,d1,d0}, 0 = blanked.
  function automatic logic [10:0] exp_pins(input int k, input logic [27:0] segs);
    int         slot;
    int         pos;
    logic [6:0] s;
    slot = (k / 8) % 4;
    pos  = k % 8;
    s    = (pos < 2) ? 7'h00 : segs[7*slot +: 7];
    return (s == 7'h00) ? {4'hF, 7'h00} : {~(4'b0001 << slot), s};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load      = 1'b1;
    digits_in = v;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if ({an_n, seg, upd, frame_done} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle k=%0d an_n=%b seg=%h upd=%b fd=%b, want an_n=1111 seg=00 upd=0 fd=0",
                 k, an_n, seg, upd, frame_done);
      end
    end
  endtask

  task automatic test_scan();
    logic [10:0] e;
    do_reset();
    lz_en = 1'b0;
    do_load(16'h4321);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      e = exp_pins(k, {7'h66, 7'h4F, 7'h5B, 7'h06});
      checks++;
      if ({an_n, seg} !== e) begin
        errors++;
        $display("FAIL scan_pins k=%0d an_n=%b seg=%h, want an_n=%b seg=%h", k, an_n, seg, e[10:7], e[6:0]);
      end
      checks++;
      if (upd !== (k == 0)) begin
        errors++;
        $display("FAIL scan_upd k=%0d upd=%b, want %b", k, upd, (k == 0));
      end
      checks++;
      if (frame_done !== (k == 32)) begin
        errors++;
        $display("FAIL scan_frame_done k=%0d fd=%b, want %b", k, frame_done, (k == 32));
      end
    end
  endtask

  task automatic test_lz();
    logic [10:0] e;
    do_reset();
    lz_en = 1'b1;
    do_load(16'h0070);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k < 32) e = exp_pins(k, {7'h00, 7'h00, 7'h07, 7'h3F});
      else        e = exp_pins(k, {7'h3F, 7'h3F, 7'h07, 7'h3F});
      checks++;
      if ({an_n, seg} !== e) begin
        errors++;
        $display("FAIL lz_pins k=%0d lz_en=%b an_n=%b seg=%h, want an_n=%b seg=%h",
                 k, lz_en, an_n, seg, e[10:7], e[6:0]);
      end
      if (k == 31) lz_en = 1'b0;
    end
  endtask

  task automatic test_invalid_bcd();
    logic [10:0] e;
    do_reset();
    lz_en = 1'b0;
    do_load(16'h12A3);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = exp_pins(k, {7'h06, 7'h5B, 7'h00, 7'h4F});
      checks++;
      if ({an_n, seg} !== e) begin
        errors++;
        $display("FAIL invalid_pins k=%0d an_n=%b seg=%h, want an_n=%b seg=%h", k, an_n, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [27:0] segs;
    do_reset();
    lz_en = 1'b0;
    do_load(16'h4321);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      case (k / 32)
        0:       segs = {7'h66, 7'h4F, 7'h5B, 7'h06};
        1:       segs = {4{7'h5B}};
        2:       segs = {4{7'h6D}};
        default: segs = {4{7'h7D}};
      endcase
      e = exp_pins(k, segs);
      checks++;
      if ({an_n, seg} !== e) begin
        errors++;
        $display("FAIL dbuf_pins k=%0d an_n=%b seg=%h, want an_n=%b seg=%h", k, an_n, seg, e[10:7], e[6:0]);
      end
      checks++;
      if (upd !== (k % 32 == 0)) begin
        errors++;
        $display("FAIL dbuf_upd k=%0d upd=%b, want %b", k, upd, (k % 32 == 0));
      end
      checks++;
      if (frame_done !== (k % 32 == 0 && k != 0)) begin
        errors++;
        $display("FAIL dbuf_frame_done k=%0d fd=%b, want %b", k, frame_done, (k % 32 == 0 && k != 0));
      end
      load = 1'b1;
      case (k)
        10:      digits_in = 16'h1111;
        20:      digits_in = 16'h2222;
        40:      digits_in = 16'h5555;
        63:      digits_in = 16'h6666;
        default: load = 1'b0;
      endcase
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic [10:0] e;
    do_reset();
    lz_en = 1'b0;
    do_load(16'h4321);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      e = exp_pins(k, {7'h66, 7'h4F, 7'h5B, 7'h06});
      checks++;
      if ({an_n, seg} !== e) begin
        errors++;
        $display("FAIL midrst_pre k=%0d an_n=%b seg=%h, want an_n=%b seg=%h", k, an_n, seg, e[10:7], e[6:0]);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({an_n, seg, upd, frame_done} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_reset an_n=%b seg=%h upd=%b fd=%b, want an_n=1111 seg=00 upd=0 fd=0",
               an_n, seg, upd, frame_done);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({an_n, seg, upd} !== {4'hF, 7'h00, 1'b0}) begin
        errors++;
        $display("FAIL midrst_idle k=%0d an_n=%b seg=%h upd=%b, want an_n=1111 seg=00 upd=0", k, an_n, seg, upd);
      end
    end
    do_load(16'h8765);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = exp_pins(k, {7'h7F, 7'h07, 7'h7D, 7'h6D});
      checks++;
      if ({an_n, seg, upd} !== {e, (k == 0)}) begin
        errors++;
        $display("FAIL midrst_restart k=%0d an_n=%b seg=%h upd=%b, want an_n=%b seg=%h upd=%b",
                 k, an_n, seg, upd, e[10:7], e[6:0], (k == 0));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    lz_en     = 1'b0;
    test_reset();
    test_scan();
    test_lz();
    test_invalid_bcd();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller that shares one `Sevenseg` BCD-to-segment decoder across `NUM_DIGITS` common-anode digits. It accepts a packed BCD word through a load strobe and double-buffers it. It rotates through the digits with a guard-blanking interval to prevent ghosting, and drives registered segment and digit-enable lines to the display pins. It sits between the system register interface and the board-level seven-segment connector.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned; must be at least 2.
- `REFRESH_DIV`, 1000, clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 2, cycles at the start of each slot with all digits off; must be at least 1.
- `clk` in 1: single clock; all logic rises on it.
- `rst_n` in 1: reset, synchronous, active-low.
- `load` in 1: one-cycle strobe; captures `digits_in`.
- `digits_in` in 4*NUM_DIGITS: packed BCD; `[3:0]` is digit 0 (least significant).
- `lz_en` in 1: leading-zero suppression enable, sampled every cycle.
- `seg` out 7: registered segments `{g,f,e,d,c,b,a}`, active-high, as produced by `Sevenseg`.
- `an_n` out NUM_DIGITS: registered digit enables, active-low, at most one low at a time.
- `upd` out 1: one-cycle pulse when the active buffer takes pending data.
- `frame_done` out 1: one-cycle pulse at the end of the slot for digit NUM_DIGITS-1.

## Operation
- Buffers:
  - `load` writes `digits_in` into the pending buffer and sets `pend`.
  - If a second `load` arrives while `pend` is set, it overwrites the pending buffer (last wins).
  - The active buffer is the only buffer the decoder sees.
- FSM states:
  - IDLE: after reset, no load seen yet. `an_n` is all 1s and `seg` = 7'h00.
  - BLANK: `an_n` is all 1s and `seg` = 7'h00. Lasts `BLANK_CYCLES` cycles.
  - SHOW: `an_n[idx]` = 0 and `seg` = decode(active[idx]). Lasts `REFRESH_DIV - BLANK_CYCLES` cycles.
- Transitions:
  - IDLE → BLANK with idx = 0 when `pend` is set.
  - BLANK → SHOW when the slot counter reaches `BLANK_CYCLES - 1`.
  - SHOW → BLANK when the slot counter reaches `REFRESH_DIV - 1`. At that point the counter clears and idx increments, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary (SHOW of idx NUM_DIGITS-1 ends, or IDLE exit):
  - If `pend` is set: active ← pending, `pend` clears, `upd` pulses.
  - A `load` in the same cycle as the boundary does the transfer first; the new data stays pending and `pend` remains set.
- Per-digit blanking: the digit is blanked (enable high, `seg` = 7'h00 for that SHOW slot) when either:
  - its BCD value is 10–15, or
  - `lz_en` = 1 and this digit and every more-significant digit are 0. Digit 0 is never suppressed.
- Slot counter width is `$clog2(REFRESH_DIV)`. idx width is `$clog2(NUM_DIGITS)`. Wrap is explicit, not by overflow.
- Reset mid-scan: on the next edge, return to IDLE, clear both buffers and `pend`, and set every output to its reset value.

## Timing
- Reset values: `seg` = 7'h00, `an_n` = all 1s, `upd` = 0, `frame_done` = 0, state IDLE, idx = 0, counter = 0.
- `load` sampled at edge t while IDLE: BLANK for digit 0 and the `upd` pulse are visible after edge t+1.
- Outputs are registered: `seg` and `an_n` change together on the same edge, with no combinational path from inputs to pins.
- Every slot is exactly `REFRESH_DIV` cycles. A frame is `NUM_DIGITS*REFRESH_DIV` cycles.
- `frame_done` is high during the first cycle of the next BLANK, the same cycle as any `upd`.
- Worst-case load-to-display latency is one frame plus 1 cycle.

## Structure
- Shared `sevenseg_pkg`: state enum `{S_IDLE, S_BLANK, S_SHOW}`, `SEG_OFF` = 7'h00, `BCD_MAX` = 4'd9.
- One sub-module: a single instance of the existing `Sevenseg` decoder. Its `bcd` is driven by the active digit mux, and its `seg` output is registered inside this block.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles, then release with no load → `an_n` = 4'hF and `seg` = 7'h00 indefinitely; `upd` and `frame_done` never pulse.
- Scan order (`REFRESH_DIV`=8, `BLANK_CYCLES`=2), load 16'h4321 → `upd` after 1 cycle. Each digit shows 2 blank cycles, then 6 cycles with an enable low:
  - digit 0: `an_n` = 4'b1110, `seg` = 7'h06
  - digit 1: `an_n` = 4'b1101, `seg` = 7'h5B
  - digit 2: `an_n` = 4'b1011, `seg` = 7'h4F
  - digit 3: `an_n` = 4'b0111, `seg` = 7'h66
  - `frame_done` pulses every 32 cycles.
- Leading-zero suppression, load 16'h0070:
  - with `lz_en` = 1 → digits 3 and 2 stay off, digit 1 shows 7'h07, digit 0 shows 7'h3F.
  - with `lz_en` = 0 → digits 3 and 2 show 7'h3F.
- Invalid BCD, load 16'h12A3 → digit 1 slot has `an_n` all 1s and `seg` = 7'h00; the other digits display normally.
- Double buffering: load 16'h1111 mid-frame, then 16'h2222 before the boundary → the current frame still shows the old value, the next frame shows 2222, `upd` pulses once. A load coincident with the boundary lands one frame later.
- Reset mid-SHOW of digit 2 → IDLE and reset outputs after the next edge; a subsequent load restarts at digit 0.
